// File: rtl/mdu_pkg.sv
// Shared types and constants for the execute-stage HI/LO multiply/divide unit.
package mdu_pkg;
    typedef enum logic [1:0] {IDLE, DIV_RUN, DIV_FIX} div_state_e;

    localparam int          DIV_ITER = 32;
    localparam logic [31:0] DIVZ_LO  = 32'hFFFF_FFFF;
endpackage

// File: rtl/mdu_if.sv
// EX-stage <-> HI/LO unit bundle: decoded controls and operands in, stall/readback out.
interface mdu_if;
    logic        ex_valid;
    logic        cancel;
    logic [1:0]  MULT;
    logic [1:0]  DIV;
    logic [1:0]  MFHL;
    logic [1:0]  MTHL;
    logic [31:0] rs_value;
    logic [31:0] rt_value;
    logic        busy;
    logic        stall_req;
    logic [31:0] hilo_rdata;

    modport master (output ex_valid, cancel, MULT, DIV, MFHL, MTHL, rs_value, rt_value,
                    input  busy, stall_req, hilo_rdata);
    modport slave  (input  ex_valid, cancel, MULT, DIV, MFHL, MTHL, rs_value, rt_value,
                    output busy, stall_req, hilo_rdata);
endinterface

// File: rtl/div_iter.sv
// Restoring divider on operand magnitudes: 32 shift/subtract cycles, then one
// sign fix-up cycle in which done pulses and the HI/LO results are presented.
module div_iter
    import mdu_pkg::*;
#(
    parameter int ITER = DIV_ITER
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);
    localparam int CW = $clog2(ITER);

    div_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d, a_q, a_d;
    logic          qneg_q, qneg_d, rneg_q, rneg_d, dvz_q, dvz_d;

    logic [31:0] abs_a, abs_b, rem_sub;
    logic [32:0] rem_sh;
    logic        ge;

    assign abs_a   = (signed_i && a_i[31]) ? -a_i : a_i;
    assign abs_b   = (signed_i && b_i[31]) ? -b_i : b_i;
    // remainder can reach 33 bits after the shift when divu uses a divisor >= 2^31
    assign rem_sh  = {rem_q, quo_q[31]};
    assign ge      = rem_sh >= {1'b0, dvsr_q};
    assign rem_sub = 32'(rem_sh - {1'b0, dvsr_q});

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvsr_q  <= '0;
            a_q     <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dvz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvsr_q  <= dvsr_d;
            a_q     <= a_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dvz_q   <= dvz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = DIV_RUN;
            DIV_RUN: if (cnt_q == '0) state_d = DIV_FIX;
            DIV_FIX: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvsr_d = dvsr_q;
        a_d    = a_q;
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        dvz_d  = dvz_q;
        case (state_q)
            IDLE: if (start_i) begin
                cnt_d  = CW'(ITER - 1);
                rem_d  = '0;
                quo_d  = abs_a;
                dvsr_d = abs_b;
                a_d    = a_i;
                qneg_d = signed_i & (a_i[31] ^ b_i[31]);
                rneg_d = signed_i & a_i[31];
                dvz_d  = (b_i == '0);
            end
            DIV_RUN: begin
                rem_d = ge ? rem_sub : rem_sh[31:0];
                quo_d = {quo_q[30:0], ge};
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        busy_o = (state_q != IDLE);
        done_o = (state_q == DIV_FIX);
        lo_o   = dvz_q ? DIVZ_LO : (qneg_q ? -quo_q : quo_q);
        hi_o   = dvz_q ? a_q     : (rneg_q ? -rem_q : rem_q);
    end
endmodule

// File: rtl/mul_div_unit.sv
// HI/LO unit for the MIPS EX stage: owns HI/LO, single-cycle multiply,
// hands divides to div_iter and stalls HI/LO instructions while it runs.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int DIV_ITER = mdu_pkg::DIV_ITER
) (
    input  logic  clk,
    input  logic  resetn,
    mdu_if.slave  bus
);
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [63:0] opa, opb, product;
    logic [31:0] div_hi, div_lo;
    logic        div_busy, div_done, issue, any_hilo;

    assign any_hilo = |{bus.MULT, bus.DIV, bus.MFHL, bus.MTHL};
    assign issue    = bus.ex_valid & ~bus.cancel & ~div_busy;

    // one 64x64 multiplier; mult sign-extends, multu zero-extends
    assign opa     = bus.MULT[0] ? {{32{bus.rs_value[31]}}, bus.rs_value} : {32'b0, bus.rs_value};
    assign opb     = bus.MULT[0] ? {{32{bus.rt_value[31]}}, bus.rt_value} : {32'b0, bus.rt_value};
    assign product = opa * opb;

    div_iter #(.ITER(DIV_ITER)) u_div (
        .clk      (clk),
        .resetn   (resetn),
        .start_i  (issue & |bus.DIV),
        .signed_i (bus.DIV[0]),
        .a_i      (bus.rs_value),
        .b_i      (bus.rt_value),
        .busy_o   (div_busy),
        .done_o   (div_done),
        .hi_o     (div_hi),
        .lo_o     (div_lo)
    );

    // div_done only occurs while busy, so it can never collide with an issue
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (div_done) begin
            hi_d = div_hi;
            lo_d = div_lo;
        end else if (issue) begin
            if (|bus.MULT) {hi_d, lo_d} = product;
            if (bus.MTHL[1]) hi_d = bus.rs_value;
            if (bus.MTHL[0]) lo_d = bus.rs_value;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign bus.busy       = div_busy;
    assign bus.stall_req  = div_busy & bus.ex_valid & any_hilo;
    assign bus.hilo_rdata = bus.MFHL[1] ? hi_q : lo_q;
endmodule
